// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: ALU opcodes, divide opcodes and the divider iteration count.
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic [1:0] {DIV, DIVU, REM, REMU} div_op_e;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider borrowing the shared ALU: 36 cycles start->done (1 on fastpath).
// No backpressure: start is only accepted in IDLE, the pipeline stalls on busy; flush aborts.
module div_sequencer
    import rv32i_pkg::*;
#(
    parameter bit FASTPATH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  div_op_e     div_op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_own,
    output alu_op_e     alu_op_o,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_res
);

    typedef enum logic [2:0] {S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX, S_DONE} state_e;

    state_e      state;
    logic [4:0]  cnt;
    logic [31:0] dvd;
    logic [31:0] divisor;
    logic [31:0] rem;
    logic        is_rem;
    logic        neg_a;
    logic        neg_b;
    logic        neg_res;

    logic        op_signed;
    logic        op_rem;
    logic [31:0] rem_sh;
    logic        cmp;

    assign op_signed = (div_op == DIV) || (div_op == REM);
    assign op_rem    = (div_op == REM) || (div_op == REMU);
    assign rem_sh    = {rem[30:0], dvd[31]};
    // rem_sh can carry a 33rd bit out of rem[31]; compare on 33 bits.
    assign cmp       = {rem[31], rem_sh} >= {1'b0, divisor};
    assign alu_own   = busy;

    always_comb begin
        alu_op_o = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            S_NEG_A: begin
                alu_op_o = neg_a ? ALU_SUB : ALU_ADD;
                alu_a    = neg_a ? 32'd0 : dvd;
                alu_b    = neg_a ? dvd : 32'd0;
            end
            S_NEG_B: begin
                alu_op_o = neg_b ? ALU_SUB : ALU_ADD;
                alu_a    = neg_b ? 32'd0 : divisor;
                alu_b    = neg_b ? divisor : 32'd0;
            end
            S_ITER: begin
                alu_op_o = ALU_SUB;
                alu_a    = rem_sh;
                alu_b    = divisor;
            end
            S_FIX: begin
                alu_op_o = neg_res ? ALU_SUB : ALU_ADD;
                alu_a    = neg_res ? 32'd0 : (is_rem ? rem : dvd);
                alu_b    = neg_res ? (is_rem ? rem : dvd) : 32'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cnt     <= '0;
            dvd     <= '0;
            divisor <= '0;
            rem     <= '0;
            is_rem  <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            neg_res <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd     <= rs1;
                        divisor <= rs2;
                        rem     <= '0;
                        cnt     <= '0;
                        is_rem  <= op_rem;
                        neg_a   <= op_signed && rs1[31];
                        neg_b   <= op_signed && rs2[31];
                        // Divide-by-zero quotient stays all-ones even for signed DIV.
                        neg_res <= op_signed && (op_rem ? rs1[31]
                                                        : (rs1[31] ^ rs2[31]) && (rs2 != 32'd0));
                        busy    <= 1'b1;
                        if (FASTPATH && rs2 == 32'd0) begin
                            result <= op_rem ? rs1 : 32'hFFFF_FFFF;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (FASTPATH && op_signed && rs1 == 32'h8000_0000
                                     && rs2 == 32'hFFFF_FFFF) begin
                            result <= op_rem ? 32'd0 : 32'h8000_0000;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state <= S_NEG_A;
                        end
                    end
                end
                S_NEG_A: begin
                    dvd   <= alu_res;
                    state <= S_NEG_B;
                end
                S_NEG_B: begin
                    divisor <= alu_res;
                    state   <= S_ITER;
                end
                S_ITER: begin
                    rem <= cmp ? alu_res : rem_sh;
                    dvd <= {dvd[30:0], cmp};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(DIV_ITERS - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    result <= alu_res;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: FASTPATH=1 and FASTPATH=0 instances, each with its own ALU model.
module tb_div_sequencer;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start0 = 1'b0;
    div_op_e     div_op = DIVU;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;

    logic        busy1, done1, alu_own1, busy0, done0, alu_own0;
    logic [31:0] result1, alu_a1, alu_b1, alu_res1;
    logic [31:0] result0, alu_a0, alu_b0, alu_res0;
    alu_op_e     alu_op1, alu_op0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_sequencer #(.FASTPATH(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start1), .div_op(div_op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy1), .done(done1), .result(result1), .alu_own(alu_own1),
        .alu_op_o(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_res(alu_res1)
    );

    div_sequencer #(.FASTPATH(1'b0)) dut_slow (
        .clk(clk), .rst(rst), .start(start0), .div_op(div_op), .rs1(rs1), .rs2(rs2),
        .flush(1'b0), .busy(busy0), .done(done0), .result(result0), .alu_own(alu_own0),
        .alu_op_o(alu_op0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_res(alu_res0)
    );

    function automatic logic [31:0] alu_model(alu_op_e op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_res1 = alu_model(alu_op1, alu_a1, alu_b1);
    always_comb alu_res0 = alu_model(alu_op0, alu_a0, alu_b0);

    // RISC-V M-extension semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_div(div_op_e op, logic [31:0] a, logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REMU: return (b == 0) ? a : a % b;
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit fp, input logic v);
        if (fp) start1 = v;
        else    start0 = v;
    endtask

    // Called #1 after an edge; the start is sampled at the next edge (edge N).
    task automatic run_op(input bit fp, input div_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input bit intrude, input string tag);
        logic [31:0] exp;
        int          lat;
        int          cyc;
        bit          busy_ok;
        bit          seen;
        exp = ref_div(op, a, b);
        lat = (fp && (b == 0 || ((op == DIV || op == REM) && a == 32'h8000_0000
                                 && b == 32'hFFFF_FFFF))) ? 1 : 36;
        div_op = op;
        rs1 = a;
        rs2 = b;
        set_start(fp, 1'b1);
        @(posedge clk); #1;
        set_start(fp, 1'b0);
        cyc = 1;
        busy_ok = 1'b1;
        seen = 1'b0;
        while (cyc <= 60) begin
            if (!(fp ? busy1 : busy0)) busy_ok = 1'b0;
            if (intrude && cyc == 3) begin
                div_op = DIVU;
                rs1 = ~a;
                rs2 = 32'd3;
                set_start(fp, 1'b1);
            end else begin
                set_start(fp, 1'b0);
            end
            if (fp ? done1 : done0) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        set_start(fp, 1'b0);
        check_val({tag, " done_cycle"}, 32'(cyc), 32'(lat));
        check_val({tag, " result"}, fp ? result1 : result0, exp);
        check_val({tag, " busy_window"}, 32'(busy_ok), 32'd1);
        if (seen) begin
            @(posedge clk); #1;
            check_val({tag, " done_pulse_end"}, 32'(fp ? done1 : done0), 32'd0);
            check_val({tag, " busy_end"}, 32'(fp ? busy1 : busy0), 32'd0);
            check_val({tag, " result_hold"}, fp ? result1 : result0, exp);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          late_done;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset busy", 32'(busy1), 32'd0);
        check_val("reset done", 32'(done1), 32'd0);
        check_val("reset result", result1, 32'd0);
        check_val("reset alu_own", 32'(alu_own1), 32'd0);
        check_val("reset slow busy", 32'(busy0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b1, DIVU, 32'd100, 32'd7, 1'b0, "divu_100_7");
        run_op(1'b1, REM, -32'd7, 32'd2, 1'b0, "rem_m7_2");
        run_op(1'b1, DIV, -32'd7, 32'd2, 1'b0, "div_m7_2");
        run_op(1'b1, REMU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "remu_33bit");
        run_op(1'b1, DIVU, 32'd5, 32'd0, 1'b0, "fast_divu_zero");
        run_op(1'b1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "fast_div_ovf");
        run_op(1'b1, REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "fast_rem_ovf");
        run_op(1'b1, DIVU, 32'd1000, 32'd10, 1'b1, "start_while_busy");
        run_op(1'b0, DIVU, 32'd5, 32'd0, 1'b0, "slow_divu_zero");
        run_op(1'b0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "slow_div_ovf");
        run_op(1'b0, DIV, -32'd7, 32'd0, 1'b0, "slow_div_neg_zero");
        run_op(1'b0, REM, -32'd7, 32'd0, 1'b0, "slow_rem_neg_zero");

        // Flush in ITER cycle 10 (cycle N+12).
        held = result1;
        div_op = DIVU;
        rs1 = 32'hFFFF_FFFF;
        rs2 = 32'd3;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_val("flush busy", 32'(busy1), 32'd0);
        check_val("flush done", 32'(done1), 32'd0);
        check_val("flush alu_own", 32'(alu_own1), 32'd0);
        check_val("flush result", result1, held);
        late_done = 0;
        repeat (40) begin
            if (done1) late_done++;
            @(posedge clk); #1;
        end
        check_val("flush no_done", 32'(late_done), 32'd0);
        run_op(1'b1, DIVU, 32'd9, 32'd3, 1'b0, "after_flush");

        // Reset in ITER cycle 5 (cycle N+7).
        div_op = DIV;
        rs1 = 32'd77;
        rs2 = 32'd5;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midreset busy", 32'(busy1), 32'd0);
        check_val("midreset done", 32'(done1), 32'd0);
        check_val("midreset result", result1, 32'd0);
        check_val("midreset alu_own", 32'(alu_own1), 32'd0);
        check_val("midreset alu_op", 32'(alu_op1), 32'(ALU_ADD));
        check_val("midreset alu_a", alu_a1, 32'd0);
        check_val("midreset alu_b", alu_b1, 32'd0);
        check_val("midreset slow alu_own", 32'(alu_own0), 32'd0);
        run_op(1'b1, DIV, 32'd12, -32'd4, 1'b0, "after_reset");

        for (int i = 0; i < 30; i++) begin
            run_op(1'b1, div_op_e'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   1'b0, "rand_fast");
            run_op(1'b0, div_op_e'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   1'b0, "rand_slow");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter FASTPATH, default 1: enables single-cycle completion for divide-by-zero and signed overflow.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  in  1  request to begin a divide; sampled only in IDLE.
REQ-005 SHALL have port div_op  in  div_op_e (2)  selects DIV, DIVU, REM or REMU.
REQ-006 SHALL have ports rs1 and rs2  in  32  dividend and divisor, sampled with start.
REQ-007 SHALL have port flush  in  1  abort of any operation in progress.
REQ-008 SHALL have port busy  out  1  high in every non-IDLE state; the pipeline stalls on it.
REQ-009 SHALL have port done  out  1  one-cycle pulse marking result valid.
REQ-010 SHALL have port result  out  32  quotient or remainder; holds until the next done.
REQ-011 SHALL have port alu_own  out  1  high when the sequencer drives the shared ALU; equal to busy.
REQ-012 SHALL have ports alu_op_o  out  alu_op_e, alu_a  out  32, alu_b  out  32: ALU operand and opcode drive.
REQ-013 SHALL have port alu_res  in  32  shared ALU result (combinational, same cycle).

Function
REQ-014 SHALL implement FSM states IDLE, NEG_A, NEG_B, ITER, FIX, DONE.
REQ-015 SHALL go IDLE->NEG_A when start=1 and flush=0; otherwise it stays in IDLE.
REQ-016 SHALL use the ALU in NEG_A to form |rs1|: ALU_SUB(0, rs1) for a signed op with rs1[31]=1, else ALU_ADD(rs1, 0); NEG_B SHALL do the same for rs2.
REQ-017 SHALL run ITER for exactly 32 cycles, counted by a 5-bit counter that wraps 31->0 on exit.
REQ-018 SHALL, in each ITER cycle, compute rem_sh = {rem[30:0], dvd[31]} and evaluate the 33-bit compare {rem[31], rem_sh} >= {0, divisor} locally; the ALU SHALL compute ALU_SUB(rem_sh, divisor); rem SHALL take alu_res if the compare is true, else rem_sh; the quotient bit SHALL be the compare outcome, shifted into dvd[0].
REQ-019 SHALL negate the result in FIX via ALU_SUB(0, x) when required (quotient: sign(rs1) XOR sign(rs2); remainder: sign(rs1); signed ops only), else use ALU_ADD(x, 0).
REQ-020 SHALL give a fixed latency: start sampled at edge N gives done=1 in cycle N+36; busy SHALL be high in cycles N+1..N+36.
REQ-021 SHALL, when FASTPATH=1 and rs2==0, go IDLE->DONE: DIV/DIVU give 0xFFFFFFFF, REM/REMU give rs1, and done SHALL be high in cycle N+1.
REQ-022 SHALL, when FASTPATH=1 and the op is DIV or REM with rs1=0x80000000 and rs2=0xFFFFFFFF, go IDLE->DONE: DIV gives 0x80000000, REM gives 0, and done SHALL be high in cycle N+1.
REQ-023 SHALL send the same rs2==0 and overflow cases through the full 36-cycle path when FASTPATH=0, with identical result values.
REQ-024 SHALL go DONE->IDLE unconditionally; a new start is therefore accepted at the earliest one cycle after done.
REQ-025 SHALL ignore start whenever busy=1.
REQ-026 SHALL move any state to IDLE at the next edge when flush=1: no done pulse, result unchanged, busy low the following cycle.
REQ-027 SHALL drop start when flush=1 and start=1 arrive together in IDLE.
REQ-028 SHALL drive alu_op_o=ALU_ADD and alu_a=alu_b=0 when alu_own=0.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state to IDLE and clear busy, done, alu_own, result, the counter and all datapath registers to 0, including mid-operation.
REQ-030 SHALL give rst priority over flush and start.

Structure
REQ-031 SHALL place div_op_e {DIV, DIVU, REM, REMU} and the constant DIV_ITERS=32 in rv32i_pkg, next to alu_op_e.
REQ-032 SHALL keep the FSM state typedef local to the module.
REQ-033 SHALL instantiate no sub-module: the existing alu is instantiated by the parent and shared through the alu_* ports, with the parent muxing on alu_own.

Verification
REQ-034 SHALL cover: DIVU 100/7 -> result 14, done at N+36, busy N+1..N+36.
REQ-035 SHALL cover: REM -7/2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD.
REQ-036 SHALL cover: REMU 0xFFFFFFFF/0x80000001 -> 0x7FFFFFFE (exercises the 33-bit compare).
REQ-037 SHALL cover, with FASTPATH=1: DIVU 5/0 -> 0xFFFFFFFF and DIV 0x80000000/-1 -> 0x80000000, each with done at N+1.
REQ-038 SHALL cover: flush in ITER cycle 10 -> no done and busy=0 next cycle; a following DIVU 9/3 -> 3 at +36; a start issued while busy is ignored.
REQ-039 SHALL cover: rst asserted in ITER cycle 5 -> all outputs 0 next cycle; a following DIV 12/-4 -> 0xFFFFFFFD.
